parking_exit_terminal: RTL and testbench
========================================

Name: parking_exit_terminal

Overview:
Exit-side kiosk controller that initiates passcode checks with the slot manager. It collects a slot number and an 8-bit passcode from the exit keypad, then issues a single `car_exit`/`exit_from`/`exit_code` request and waits for the match result. On a match it drives the exit gate; on a mismatch it counts failed attempts and locks the keypad after repeated failures.

Parameters:
- KEY_TIMEOUT, 1000: max idle cycles between keypad digits before the partial entry is discarded.
- RESP_TIMEOUT, 64: max cycles waiting for `match_valid` after a request.
- GATE_CYCLES, 500: minimum cycles `gate_open` stays high.
- MAX_TRIES, 3: failed attempts allowed before lockout (1..3).
- LOCK_CYCLES, 2000: lockout duration in cycles.

Ports:
- clock  in  1  system clock, rising edge
- gl_reset  in  1  asynchronous, active-high reset
- key_valid  in  1  one-cycle strobe; a keypad nibble is present
- key_data  in  4  keypad nibble (hex digit)
- key_clear  in  1  user cancel; discards the partial entry
- car_present  in  1  vehicle sensor under the gate
- car_exit  out  1  one-cycle request pulse to the slot manager
- exit_from  out  3  slot number of the request
- exit_code  out  8  passcode of the request
- match_valid  in  1  one-cycle response strobe from the slot manager
- match_ok  in  1  response result, sampled only when `match_valid` is high
- gate_open  out  1  exit barrier raise command
- busy  out  1  high in every state except IDLE
- err_pulse  out  1  one-cycle pulse on bad digit, key timeout or response timeout
- locked  out  1  high during lockout
- tries_left  out  2  remaining attempts

Behaviour:
- Reset values: all outputs 0 except `tries_left` = MAX_TRIES.
- Reset clears the FSM to IDLE and zeroes all timers; this applies mid-request or mid-gate as well, so the gate closes immediately.
- FSM states: IDLE, CODE_HI, CODE_LO, REQ, WAIT_RESP, OPEN, LOCKED.
- IDLE:
  - `key_valid` with `key_data` ≤ 7: latch `exit_from` = `key_data[2:0]`, go to CODE_HI.
  - `key_data` 8..F: `err_pulse`, stay in IDLE.
- CODE_HI: `key_valid` latches `exit_code[7:4]`, go to CODE_LO.
- CODE_LO: `key_valid` latches `exit_code[3:0]`, go to REQ.
- Key timer (CODE_HI/CODE_LO):
  - Reloads on every accepted key.
  - On reaching KEY_TIMEOUT: `err_pulse`, return to IDLE. Tries are not consumed.
- `key_clear` in IDLE/CODE_HI/CODE_LO returns to IDLE with no error. It has priority over a simultaneous `key_valid`.
- REQ: `car_exit` = 1 for exactly one cycle, then go to WAIT_RESP.
- `exit_from`/`exit_code` are stable from REQ until WAIT_RESP exits. They hold their last value afterwards.
- WAIT_RESP:
  - `match_valid` & `match_ok`: `tries_left` reloads to MAX_TRIES, go to OPEN.
  - `match_valid` & !`match_ok`: `tries_left` decrements. If the result is 0, go to LOCKED; otherwise go to IDLE.
  - No `match_valid` within RESP_TIMEOUT cycles: `err_pulse`, go to IDLE. Tries are not consumed.
  - `key_valid`/`key_clear` are ignored.
- `match_valid` outside WAIT_RESP is ignored.
- OPEN:
  - `gate_open` = 1 from the first OPEN cycle.
  - Leave for IDLE when the gate timer reaches GATE_CYCLES and `car_present` = 0. The gate never closes on a car.
  - Keys are ignored.
- LOCKED:
  - `locked` = 1; all keys are ignored.
  - After LOCK_CYCLES: `tries_left` = MAX_TRIES, go to IDLE.
- Timers: a single shared down-counter, width `$clog2` of the largest timing parameter plus 1. It reloads on every state entry. No wrap: it saturates at 0.
- Simultaneous `key_valid` and the key-timeout expiry in the same cycle: the key wins and the timer reloads.

Decomposition:
- Shared package `parking_pkg`:
  - State enum `exit_state_t`.
  - SLOT_W = 3, CODE_W = 8.
  - Function `slot_passcode(slot)` giving the cumulative Fibonacci code: slot0 = 1, slot1 = 3, slot2 = 6, slot3 = 11, slot4 = 19, slot5 = 32, slot6 = 53, slot7 = 87. It is used by the slot manager and by the bench model.
- One natural sub-module: `exit_timer` (loadable saturating down-counter with `load`, `load_val`, `expired`).
- Everything else stays flat.

Test Plan:
- Slot 3, keys 3,0,B; manager replies `match_ok` = 1 two cycles after the request → one `car_exit` pulse with `exit_from` = 3 and `exit_code` = 0x0B; `gate_open` high for ≥ 500 cycles; `tries_left` = 3.
- Gate extension: `car_present` held high until cycle 700 of OPEN → `gate_open` drops the cycle after `car_present` falls, not at cycle 500.
- Three wrong codes for slot 7 (keys 7,5,6 each attempt, mismatch each time) → `tries_left` 2, 1, then `locked` = 1 for 2000 cycles. Keys during lockout produce no `car_exit`. Afterwards `tries_left` = 3 and keys 7,5,7 (0x57) → gate opens.
- Key 9 in IDLE → `err_pulse` and no state change. Keys 2,0 then 1001 idle cycles → `err_pulse`, back to IDLE, `busy` = 0, `tries_left` unchanged.
- No response: keys 1,0,3, manager silent → `err_pulse` 64 cycles after `car_exit`, IDLE, `tries_left` still 3.
- `gl_reset` asserted mid-OPEN and again mid-WAIT_RESP → `gate_open`/`busy` drop asynchronously, `tries_left` = 3. A later `match_valid` produces no effect.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking slot manager and its exit kiosk.
package parking_pkg;

  localparam int SLOT_W = 3;
  localparam int CODE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CODE_HI,
    CODE_LO,
    REQ,
    WAIT_RESP,
    OPEN,
    LOCKED
  } exit_state_t;

  // Passcode of a slot: running sum of the Fibonacci series 1,2,3,5,8,...
  function automatic logic [CODE_W-1:0] slot_passcode(input logic [SLOT_W-1:0] slot);
    logic [CODE_W-1:0] fib_a;
    logic [CODE_W-1:0] fib_b;
    logic [CODE_W-1:0] fib_t;
    logic [CODE_W-1:0] sum;
    fib_a = 8'd1;
    fib_b = 8'd2;
    sum   = 8'd0;
    for (int i = 0; i < (1 << SLOT_W); i++) begin
      if (i <= int'(slot)) sum = sum + fib_a;
      fib_t = fib_a + fib_b;
      fib_a = fib_b;
      fib_b = fib_t;
    end
    return sum;
  endfunction

endpackage

// File: rtl/exit_timer.sv
// Loadable down-counter shared by all timed kiosk states; sticks at zero.
module exit_timer #(
  parameter int W = 12
) (
  input  logic         clock,
  input  logic         gl_reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] r_count;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge gl_reset) begin
    if (gl_reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expired = (r_count == '0);

endmodule

// File: rtl/parking_exit_terminal.sv
// Exit kiosk: gathers slot + passcode from the keypad, asks the slot manager,
// then raises the gate or counts the failure towards a keypad lockout.
module parking_exit_terminal
  import parking_pkg::*;
#(
  parameter int KEY_TIMEOUT  = 1000,
  parameter int RESP_TIMEOUT = 64,
  parameter int GATE_CYCLES  = 500,
  parameter int MAX_TRIES    = 3,
  parameter int LOCK_CYCLES  = 2000
) (
  input  logic              clock,
  input  logic              gl_reset,
  input  logic              key_valid,
  input  logic [3:0]        key_data,
  input  logic              key_clear,
  input  logic              car_present,
  output logic              car_exit,
  output logic [SLOT_W-1:0] exit_from,
  output logic [CODE_W-1:0] exit_code,
  input  logic              match_valid,
  input  logic              match_ok,
  output logic              gate_open,
  output logic              busy,
  output logic              err_pulse,
  output logic              locked,
  output logic [1:0]        tries_left
);

  localparam int MAX_KR  = (KEY_TIMEOUT > RESP_TIMEOUT) ? KEY_TIMEOUT : RESP_TIMEOUT;
  localparam int MAX_GL  = (GATE_CYCLES > LOCK_CYCLES) ? GATE_CYCLES : LOCK_CYCLES;
  localparam int TIMER_W = $clog2((MAX_KR > MAX_GL) ? MAX_KR : MAX_GL) + 1;
  localparam logic [1:0] TRIES_FULL = 2'(MAX_TRIES);

  exit_state_t       r_state;
  exit_state_t       w_next;
  logic [1:0]        r_tries;
  logic [SLOT_W-1:0] r_from;
  logic [CODE_W-1:0] r_code;
  logic              w_key;
  logic              w_load;
  logic              w_expired;
  logic              w_err;
  logic [TIMER_W-1:0] w_load_val;

  // Cancel beats a simultaneous digit.
  assign w_key = key_valid & ~key_clear;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_next     = r_state;
    w_err      = 1'b0;
    w_load_val = '0;
    case (r_state)
      IDLE: begin
        if (w_key) begin
          if (!key_data[3]) w_next = CODE_HI;
          else              w_err  = 1'b1;
        end
      end
      CODE_HI: begin
        if (key_clear)      w_next = IDLE;
        else if (key_valid) w_next = CODE_LO;
        else if (w_expired) begin
          w_err  = 1'b1;
          w_next = IDLE;
        end
      end
      CODE_LO: begin
        if (key_clear)      w_next = IDLE;
        else if (key_valid) w_next = REQ;
        else if (w_expired) begin
          w_err  = 1'b1;
          w_next = IDLE;
        end
      end
      REQ: w_next = WAIT_RESP;
      WAIT_RESP: begin
        if (match_valid) begin
          if (match_ok)             w_next = OPEN;
          else if (r_tries <= 2'd1) w_next = LOCKED;
          else                      w_next = IDLE;
        end else if (w_expired) begin
          w_err  = 1'b1;
          w_next = IDLE;
        end
      end
      OPEN:    if (w_expired && !car_present) w_next = IDLE;
      LOCKED:  if (w_expired) w_next = IDLE;
      default: w_next = IDLE;
    endcase

    // Loaded with limit-1 so expiry lands on the limit-th cycle in the state.
    case (w_next)
      CODE_HI, CODE_LO: w_load_val = TIMER_W'(KEY_TIMEOUT - 1);
      WAIT_RESP:        w_load_val = TIMER_W'(RESP_TIMEOUT - 1);
      OPEN:             w_load_val = TIMER_W'(GATE_CYCLES - 1);
      LOCKED:           w_load_val = TIMER_W'(LOCK_CYCLES - 1);
      default:          w_load_val = '0;
    endcase
  end

  assign w_load = (w_next != r_state);

  exit_timer #(.W(TIMER_W)) u_timer (
    .clock    (clock),
    .gl_reset (gl_reset),
    .load     (w_load),
    .load_val (w_load_val),
    .expired  (w_expired)
  );

  always_ff @(posedge clock or posedge gl_reset) begin
    if (gl_reset) begin
      r_state <= IDLE;
      r_tries <= TRIES_FULL;
      r_from  <= '0;
      r_code  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE:      if (w_key && !key_data[3]) r_from <= key_data[SLOT_W-1:0];
        CODE_HI:   if (w_key) r_code[CODE_W-1 -: 4] <= key_data;
        CODE_LO:   if (w_key) r_code[3:0] <= key_data;
        WAIT_RESP: if (match_valid) r_tries <= match_ok ? TRIES_FULL : r_tries - 2'd1;
        LOCKED:    if (w_expired) r_tries <= TRIES_FULL;
        default:   ;
      endcase
    end
  end

  assign car_exit   = (r_state == REQ);
  assign exit_from  = r_from;
  assign exit_code  = r_code;
  assign gate_open  = (r_state == OPEN);
  assign busy       = (r_state != IDLE);
  assign err_pulse  = w_err;
  assign locked     = (r_state == LOCKED);
  assign tries_left = r_tries;

endmodule

// File: tb/tb_parking_exit_terminal.sv
// Self-checking bench for the exit kiosk: directed scenarios plus random traffic,
// all compared every cycle against a phase/age model of the kiosk rules.
module tb_parking_exit_terminal;

  localparam int KEY_TO  = 1000;
  localparam int RESP_TO = 64;
  localparam int GATE_N  = 500;
  localparam int TRIES   = 3;
  localparam int LOCK_N  = 2000;

  localparam int P_ENTRY   = 0;
  localparam int P_REQUEST = 1;
  localparam int P_WAITING = 2;
  localparam int P_GATE    = 3;
  localparam int P_LOCK    = 4;

  localparam int W_CAR       = 0;
  localparam int W_GATE_HI   = 1;
  localparam int W_GATE_LO   = 2;
  localparam int W_NOT_BUSY  = 3;
  localparam int W_LOCKED    = 4;
  localparam int W_UNLOCKED  = 5;

  logic       clock     = 1'b0;
  logic       gl_reset  = 1'b1;
  logic       key_valid = 1'b0;
  logic       key_clear = 1'b0;
  logic [3:0] key_data  = 4'd0;
  logic       car_dir   = 1'b0;
  logic       car_rand  = 1'b0;
  logic       rand_mode = 1'b0;
  logic       mgr_mv    = 1'b0;
  logic       mgr_ok    = 1'b0;
  logic       man_mv    = 1'b0;
  logic       man_ok    = 1'b0;
  logic       car_present;
  logic       match_valid;
  logic       match_ok;

  assign car_present = car_dir | (rand_mode & car_rand);
  assign match_valid = mgr_mv | man_mv;
  assign match_ok    = mgr_ok | man_ok;

  logic       car_exit;
  logic [2:0] exit_from;
  logic [7:0] exit_code;
  logic       gate_open;
  logic       busy;
  logic       err_pulse;
  logic       locked;
  logic [1:0] tries_left;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: phase of the transaction, digits collected, cycles spent.
  int         m_phase  = P_ENTRY;
  int         m_digits = 0;
  int         m_age    = 0;
  int         m_tries  = TRIES;
  logic [2:0] m_from   = 3'd0;
  logic [7:0] m_code   = 8'd0;

  int   mgr_delay  = 2;
  logic mgr_silent = 1'b0;
  logic mgr_random = 1'b0;

  int gate_run = 0, gate_last = 0, lock_run = 0, lock_last = 0;
  int err_cnt = 0, car_cnt = 0, car_cyc = 0, err_cyc = 0;

  logic [7:0] pc_tab [8];

  parking_exit_terminal dut (
    .clock       (clock),
    .gl_reset    (gl_reset),
    .key_valid   (key_valid),
    .key_data    (key_data),
    .key_clear   (key_clear),
    .car_present (car_present),
    .car_exit    (car_exit),
    .exit_from   (exit_from),
    .exit_code   (exit_code),
    .match_valid (match_valid),
    .match_ok    (match_ok),
    .gate_open   (gate_open),
    .busy        (busy),
    .err_pulse   (err_pulse),
    .locked      (locked),
    .tries_left  (tries_left)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_data  = d;
    step(1);
    key_valid = 1'b0;
  endtask

  function automatic logic cond(input int which);
    case (which)
      W_CAR:      return car_exit;
      W_GATE_HI:  return gate_open;
      W_GATE_LO:  return !gate_open;
      W_NOT_BUSY: return !busy;
      W_LOCKED:   return locked;
      W_UNLOCKED: return !locked;
      default:    return 1'b0;
    endcase
  endfunction

  // Waits for a condition on a falling edge, then realigns to just after the next rising edge.
  task automatic wait_for(input string name, input int which, input int limit);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (cond(which)) begin
        seen = 1'b1;
        break;
      end
    end
    check({"wait_", name}, 32'(seen), 32'd1);
    @(posedge clock);
    #1;
  endtask

  function automatic logic exp_err();
    if (m_phase == P_ENTRY && !key_clear) begin
      if (m_digits == 0) return key_valid && (key_data > 4'd7);
      return !key_valid && (m_age >= KEY_TO - 1);
    end
    if (m_phase == P_WAITING) return !match_valid && (m_age >= RESP_TO - 1);
    return 1'b0;
  endfunction

  always @(posedge clock or posedge gl_reset) begin
    int ph, dg, ag, tr;
    logic [2:0] fr;
    logic [7:0] cd;
    if (gl_reset) begin
      m_phase  <= P_ENTRY;
      m_digits <= 0;
      m_age    <= 0;
      m_tries  <= TRIES;
      m_from   <= 3'd0;
      m_code   <= 8'd0;
    end else begin
      ph = m_phase; dg = m_digits; ag = m_age + 1; tr = m_tries; fr = m_from; cd = m_code;
      case (m_phase)
        P_ENTRY: begin
          if (key_clear) dg = 0;
          else if (key_valid && dg == 0) begin
            if (key_data <= 4'd7) begin
              fr = key_data[2:0];
              dg = 1;
              ag = 0;
            end
          end else if (key_valid && dg == 1) begin
            cd[7:4] = key_data;
            dg = 2;
            ag = 0;
          end else if (key_valid) begin
            cd[3:0] = key_data;
            dg = 0;
            ph = P_REQUEST;
          end else if (dg > 0 && m_age >= KEY_TO - 1) dg = 0;
        end
        P_REQUEST: ph = P_WAITING;
        P_WAITING: begin
          if (match_valid) begin
            if (match_ok) begin
              tr = TRIES;
              ph = P_GATE;
            end else begin
              tr = tr - 1;
              ph = (tr == 0) ? P_LOCK : P_ENTRY;
            end
          end else if (m_age >= RESP_TO - 1) ph = P_ENTRY;
        end
        P_GATE: if (m_age >= GATE_N - 1 && !car_present) ph = P_ENTRY;
        P_LOCK: if (m_age >= LOCK_N - 1) begin
          tr = TRIES;
          ph = P_ENTRY;
        end
        default: ph = P_ENTRY;
      endcase
      if (ph != m_phase) ag = 0;
      m_phase  <= ph;
      m_digits <= dg;
      m_age    <= ag;
      m_tries  <= tr;
      m_from   <= fr;
      m_code   <= cd;
    end
  end

  always @(negedge clock) begin
    check("car_exit",   32'(car_exit),   32'(m_phase == P_REQUEST));
    check("gate_open",  32'(gate_open),  32'(m_phase == P_GATE));
    check("locked",     32'(locked),     32'(m_phase == P_LOCK));
    check("busy",       32'(busy),       32'(!(m_phase == P_ENTRY && m_digits == 0)));
    check("err_pulse",  32'(err_pulse),  32'(exp_err()));
    check("tries_left", 32'(tries_left), 32'(m_tries));
    check("exit_from",  32'(exit_from),  32'(m_from));
    check("exit_code",  32'(exit_code),  32'(m_code));
  end

  always @(negedge clock) begin
    if (gate_open) gate_run++;
    else if (gate_run > 0) begin
      gate_last = gate_run;
      gate_run  = 0;
    end
    if (locked) lock_run++;
    else if (lock_run > 0) begin
      lock_last = lock_run;
      lock_run  = 0;
    end
    if (err_pulse) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (car_exit) begin
      car_cnt++;
      car_cyc = cyc;
    end
  end

  always @(posedge clock) begin
    #1;
    car_rand = ($urandom_range(0, 3) == 0);
  end

  // Slot manager stand-in: answers each request after a delay, judging it with the package passcode.
  initial begin
    int   d;
    logic ok;
    forever begin
      @(negedge clock);
      if (car_exit && !gl_reset) begin
        d  = mgr_random ? int'($urandom_range(1, 72)) : mgr_delay;
        ok = (m_code == parking_pkg::slot_passcode(m_from));
        if (!mgr_silent && d <= RESP_TO) begin
          step(d);
          mgr_mv = 1'b1;
          mgr_ok = ok;
          step(1);
          mgr_mv = 1'b0;
          mgr_ok = 1'b0;
        end
      end
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, e0;
    pc_tab = '{8'd1, 8'd3, 8'd6, 8'd11, 8'd19, 8'd32, 8'd53, 8'd87};
    for (int i = 0; i < 8; i++)
      check("slot_passcode", 32'(parking_pkg::slot_passcode(3'(i))), 32'(pc_tab[i]));

    // Reset values
    step(3);
    check("rst_tries", 32'(tries_left), 32'd3);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_gate",  32'(gate_open),  32'd0);
    check("rst_from",  32'(exit_from),  32'd0);
    check("rst_code",  32'(exit_code),  32'd0);
    #2 gl_reset = 1'b0;
    step(2);

    // Slot 3 with the right code, reply two cycles after the request
    press(4'd3); press(4'd0); press(4'hB);
    wait_for("req1", W_CAR, 5);
    check("req1_from", 32'(exit_from), 32'd3);
    check("req1_code", 32'(exit_code), 32'h0B);
    wait_for("gate1", W_GATE_HI, 10);
    wait_for("gate1_close", W_GATE_LO, 600);
    check("gate1_len", 32'(gate_last), 32'd500);
    check("gate1_tries", 32'(tries_left), 32'd3);

    // Car under the gate until OPEN cycle 700
    car_dir = 1'b1;
    press(4'd3); press(4'd0); press(4'hB);
    wait_for("gate2", W_GATE_HI, 20);
    step(698);
    car_dir = 1'b0;
    wait_for("gate2_close", W_GATE_LO, 5);
    check("gate2_len", 32'(gate_last), 32'd700);

    // Three wrong codes for slot 7, then lockout
    for (int a = 0; a < 3; a++) begin
      press(4'd7); press(4'd5); press(4'd6);
      wait_for("bad_req", W_CAR, 5);
      if (a < 2) begin
        wait_for("bad_idle", W_NOT_BUSY, 10);
        check("bad_tries", 32'(tries_left), 32'(2 - a));
      end
    end
    wait_for("lock", W_LOCKED, 10);
    check("lock_tries", 32'(tries_left), 32'd0);
    c0 = car_cnt;
    step(5);
    press(4'd7); press(4'd5); press(4'd7);
    wait_for("unlock", W_UNLOCKED, 2100);
    check("lock_len", 32'(lock_last), 32'd2000);
    check("lock_no_req", 32'(car_cnt), 32'(c0));
    check("unlock_tries", 32'(tries_left), 32'd3);
    press(4'd7); press(4'd5); press(4'd7);
    wait_for("gate3", W_GATE_HI, 10);
    wait_for("gate3_close", W_GATE_LO, 600);

    // Bad slot digit, then key timeout
    e0 = err_cnt;
    press(4'd9);
    check("bad_digit_err", 32'(err_cnt), 32'(e0 + 1));
    check("bad_digit_busy", 32'(busy), 32'd0);
    press(4'd2); press(4'd0);
    step(1001);
    check("key_to_err", 32'(err_cnt), 32'(e0 + 2));
    check("key_to_busy", 32'(busy), 32'd0);
    check("key_to_tries", 32'(tries_left), 32'd3);

    // Silent manager: response timeout
    mgr_silent = 1'b1;
    press(4'd1); press(4'd0); press(4'd3);
    wait_for("silent_req", W_CAR, 5);
    wait_for("silent_idle", W_NOT_BUSY, 80);
    check("resp_to_delay", 32'(err_cyc - car_cyc), 32'd64);
    check("resp_to_tries", 32'(tries_left), 32'd3);
    mgr_silent = 1'b0;

    // Reset in the middle of OPEN
    car_dir = 1'b1;
    press(4'd3); press(4'd0); press(4'hB);
    wait_for("gate4", W_GATE_HI, 10);
    step(50);
    #2 gl_reset = 1'b1;
    #1;
    check("rst_open_gate", 32'(gate_open), 32'd0);
    check("rst_open_busy", 32'(busy), 32'd0);
    car_dir = 1'b0;
    step(2);
    gl_reset = 1'b0;
    step(2);

    // One failure, then reset in the middle of WAIT_RESP
    press(4'd3); press(4'd0); press(4'd0);
    wait_for("fail_req", W_CAR, 5);
    wait_for("fail_idle", W_NOT_BUSY, 10);
    check("fail_tries", 32'(tries_left), 32'd2);
    mgr_silent = 1'b1;
    press(4'd3); press(4'd0); press(4'hB);
    wait_for("wait_req", W_CAR, 5);
    step(5);
    #2 gl_reset = 1'b1;
    #1;
    check("rst_wait_busy", 32'(busy), 32'd0);
    check("rst_wait_tries", 32'(tries_left), 32'd3);
    step(2);
    gl_reset = 1'b0;
    step(2);
    man_mv = 1'b1;
    man_ok = 1'b1;
    step(1);
    man_mv = 1'b0;
    man_ok = 1'b0;
    step(3);
    check("late_match_gate", 32'(gate_open), 32'd0);
    check("late_match_busy", 32'(busy), 32'd0);
    mgr_silent = 1'b0;

    // Random traffic
    rand_mode  = 1'b1;
    mgr_random = 1'b1;
    for (int it = 0; it < 30; it++) begin
      int         slot;
      logic [7:0] code;
      logic [3:0] dig [3];
      slot   = int'($urandom_range(0, 7));
      code   = ($urandom_range(0, 1) == 1) ? parking_pkg::slot_passcode(3'(slot)) : 8'($urandom);
      dig[0] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'(slot);
      dig[1] = code[7:4];
      dig[2] = code[3:0];
      for (int k = 0; k < 3; k++) begin
        step((it % 13 == 7 && k == 1) ? KEY_TO + 1 : int'($urandom_range(0, 3)));
        if ($urandom_range(0, 15) == 0) begin
          key_clear = 1'b1;
          key_valid = 1'($urandom_range(0, 1));
          key_data  = dig[k];
          step(1);
          key_clear = 1'b0;
          key_valid = 1'b0;
        end else begin
          press(dig[k]);
        end
      end
      if ($urandom_range(0, 9) == 0) begin
        man_ok = 1'($urandom_range(0, 1));
        man_mv = 1'b1;
        step(1);
        man_mv = 1'b0;
        man_ok = 1'b0;
      end
      step(int'($urandom_range(0, 300)));
    end
    rand_mode  = 1'b0;
    mgr_random = 1'b0;
    step(100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
